// File: rtl/fp_pkg.sv
// fp_pkg: binary32 constants, field positions and squarer state encoding shared by the fp units
package fp_pkg;
  localparam int FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_HI = 30;
  localparam int FP_EXP_LO = 23;
  localparam int FP_FRAC_HI = 22;
  localparam int FP_FRAC_LO = 0;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} fp_sq_state_t;
endpackage

// File: rtl/fp_mant_mul_seq.sv
// fp_mant_mul_seq: iterative shift-add unsigned multiplier, one multiplier bit per clock
module fp_mant_mul_seq #(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W);
  logic [2*W-1:0] a_sh;
  logic [W-1:0]   b_sh;
  logic [CW-1:0]  cnt;
  logic           run;
  // done flags the cycle whose edge folds in the final partial product
  assign done = run && cnt == CW'(W - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      cnt <= '0;
      run <= 1'b0;
      product <= '0;
    end else if (start) begin
      a_sh <= {{W{1'b0}}, a};
      b_sh <= b;
      cnt <= '0;
      run <= 1'b1;
      product <= '0;
    end else if (run) begin
      product <= product + (b_sh[0] ? a_sh : '0);
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt <= cnt + 1'b1;
      run <= !done;
    end
  end
endmodule

// File: rtl/fp_square.sv
// fp_square: sequential binary32 squarer with start/done handshake; NaN/Inf/zero short-circuit
module fp_square import fp_pkg::*; #(
  parameter int DATAWIDTH = 32,
  parameter int MANT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] data_i,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] data_o
);
  fp_sq_state_t     state;
  logic [7:0]       exp_r;
  logic [7:0]       in_exp;
  logic [22:0]      in_frac;
  logic             is_special;
  logic [31:0]      special_val;
  logic             mul_start;
  logic             mul_done;
  logic [2*MANT_W-1:0] prod;
  logic             hi;
  logic [22:0]      frac;
  logic             guard;
  logic             sticky;
  logic [23:0]      rounded;
  logic [9:0]       e_pre;
  logic [9:0]       e_fin;
  logic [31:0]      norm_res;
  assign in_exp = data_i[FP_EXP_HI:FP_EXP_LO];
  assign in_frac = data_i[FP_FRAC_HI:FP_FRAC_LO];
  // subnormals are flushed, so exponent 0 is treated like a true zero
  assign is_special = in_exp == 8'h00 || in_exp == 8'hFF;
  assign special_val = in_exp == 8'hFF ? (|in_frac ? FP_QNAN : FP_POS_INF) : 32'h0;
  assign mul_start = state == S_IDLE && start && !is_special;
  fp_mant_mul_seq #(.W(MANT_W)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(mul_start),
    .a({1'b1, in_frac}),
    .b({1'b1, in_frac}),
    .done(mul_done),
    .product(prod)
  );
  // product lies in [1,4): bit 47 selects which 23 bits form the fraction
  always_comb begin
    hi = prod[47];
    frac = hi ? prod[46:24] : prod[45:23];
    guard = hi ? prod[23] : prod[22];
    sticky = hi ? |prod[22:0] : |prod[21:0];
    rounded = {1'b0, frac} + {23'b0, guard & (sticky | frac[0])};
    e_pre = {1'b0, exp_r, 1'b0} - 10'(FP_BIAS) + {9'b0, hi};
    e_fin = e_pre + {9'b0, rounded[23]};
    norm_res = $signed(e_fin) >= 10'sd255 ? FP_POS_INF :
               $signed(e_fin) <= 10'sd0 ? 32'h0 : {1'b0, e_fin[7:0], rounded[22:0]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      exp_r <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      data_o <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          exp_r <= in_exp;
          if (is_special) begin
            data_o <= special_val;
            done <= 1'b1;
            state <= S_DONE;
          end else begin
            busy <= 1'b1;
            state <= S_MUL;
          end
        end
        S_MUL: if (mul_done) state <= S_NORM;
        S_NORM: begin
          data_o <= norm_res;
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_DONE;
        end
        default: begin
          done <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/fp_square.md
# fp_square

Sequential IEEE-754 single-precision squarer: computes `data_o = data_i * data_i` with an iterative shift-add mantissa multiplier and a start/done handshake. It is the inverse companion to the floating-point square-root unit. The sqrt result is fed back through this block and compared against the original operand in self-checking benches and on-chip test. Area is kept small deliberately, at the cost of a multi-cycle latency.

## Interface
- `DATAWIDTH`, 32: operand/result width; only 32 (binary32) is supported.
- `MANT_W`, 24: significand width including the hidden bit; sets the iteration count.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `data_i`  in  32  operand; captured on the accepted `start` cycle.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse; `data_o` is valid from this cycle onward.
- `data_o`  out  32  registered result; holds until the next `done`.

## Operation
- **Decided:** one clock; reset is asynchronous and active-high; ports are `clk` and `rst`.
- **Reset values:** `busy`=0, `done`=0, `data_o`=0x00000000, state=IDLE.
- **States:** IDLE, MUL, NORM, DONE.
  - IDLE: if `start`=1, capture `data_i` and classify it.
    - Special operand: go directly to DONE.
    - Otherwise: go to MUL.
  - MUL: runs `MANT_W` cycles. Each cycle, if multiplier bit i is set, the 48-bit accumulator adds the shifted multiplicand, then i increments.
  - NORM: one cycle of normalize, round, and exponent check.
  - DONE: `done`=1, `data_o` updated; return to IDLE.
- **Special operands:** sign of the input is ignored.
  - NaN → 0x7FC00000 (canonical quiet NaN).
  - ±Inf → 0x7F800000.
  - ±0 → 0x00000000.
  - Subnormal input → flushed to zero, result 0x00000000.
- **Sign:** the result sign is always 0.
- **Exponent:** computed in 10-bit signed arithmetic as e = 2·E − 127.
  - The product P (48 bits) lies in [1,4). If P[47]=1, use P[46:24] as the fraction with P[23:0] as round bits, and e += 1. Otherwise use P[45:23] with P[22:0].
- **Rounding:** round-to-nearest-even. A mantissa carry-out renormalizes and adds 1 to e.
- **Range:** after rounding, e ≥ 255 → 0x7F800000; e ≤ 0 → 0x00000000 (flush, no subnormal output).
- **Busy rule:** `start` while `busy` is ignored; the operand is not recaptured.
- **Back-to-back:** `start` in the same cycle as `done` is ignored. A new `start` is accepted the cycle after `done`.

## Timing
- Latency is counted from the rising edge that samples `start`=1 (cycle 0).
- **Special operand:** `done` and `data_o` valid at cycle 1; `busy` stays 0.
- **Normal operand:**
  - `busy`=1 during cycles 1..`MANT_W`+1.
  - MUL occupies cycles 1..24 and NORM cycle 25.
  - `done` is asserted at cycle 26 with `busy`=0.
- **Throughput:** one result per 27 cycles (normal operands).
- **Reset mid-operation:** all outputs return to their reset values immediately (asynchronous). The in-flight result is discarded and no `done` is produced.

## Structure
- Shared package `fp_pkg`:
  - `FP_BIAS` = 127.
  - `FP_QNAN` = 32'h7FC00000, `FP_POS_INF` = 32'h7F800000.
  - Field-slice constants (sign, exponent, fraction positions).
  - State enum `fp_sq_state_t`.
  - The sqrt unit and checker reuse these.
- Sub-module `fp_mant_mul_seq`:
  - Iterative 24×24 shift-add multiplier.
  - Ports: `start`, operands, `done`, 48-bit product.
  - `fp_square` wraps it with classification, normalize/round, and the handshake FSM.

## Test plan
- Basic square: reset, then `start` with 0x40000000 (2.0) → `done` exactly at cycle 26 with `data_o`=0x40800000 (4.0); `busy` high cycles 1–25.
- Negative and non-power-of-two inputs:
  - 0xC0400000 (−3.0) → 0x41100000 (9.0).
  - 0x3FC00000 (1.5) → 0x40100000 (2.25).
- Rounding: 0x3F800001 (1+2⁻²³) → 0x3F800002; the 2⁻⁴⁶ term is dropped under round-to-nearest-even.
- Range limits:
  - 0x7F7FFFFF → 0x7F800000 (overflow).
  - 0x1E3CE508 (~1e-20) → 0x00000000 (underflow).
  - 0x00000001 (subnormal) → 0x00000000 at cycle 1.
- Special operands at cycle 1:
  - 0xFFC00001 (NaN) → 0x7FC00000.
  - 0xFF800000 (−Inf) → 0x7F800000.
- Handshake:
  - `start` with a different operand at cycle 10 is ignored; the result is still the first operand's square.
  - Assert `rst` at cycle 12 of a square → outputs zero immediately, no `done`.
  - After reset, a fresh 2.0 request completes normally.
